// File: rtl/mul_seq.sv
// Multi-cycle shift-add multiplier that borrows the shared ALU one op per granted cycle.
// Optional feature: define MULSEQ_EARLY_EXIT_EN to finish as soon as the multiplier runs out of set bits.
`timescale 1ns/1ps

`ifndef WORDSIZE
`define WORDSIZE 64
`endif
`ifndef SHAMTSIZE
`define SHAMTSIZE 6
`endif
`ifndef ALUOPSIZE
`define ALUOPSIZE 6
`endif
`ifndef ALUOP_ADD
`define ALUOP_ADD 2'b00
`endif

module mul_seq (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [`WORDSIZE-1:0]  in_a,
    input  logic [`WORDSIZE-1:0]  in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [`WORDSIZE-1:0]  out_prod,
    output logic                  alu_req,
    input  logic                  alu_gnt,
    output logic [`WORDSIZE-1:0]  alu_a,
    output logic [`WORDSIZE-1:0]  alu_b,
    output logic [`SHAMTSIZE-1:0] alu_shamt,
    output logic [`ALUOPSIZE-1:0] alu_aluop,
    input  logic [`WORDSIZE-1:0]  alu_res
);
    localparam int W  = `WORDSIZE;
    localparam int CW = $clog2(W) + 1;

    // aluop = {inv_a, inv_b, shift_en, dir_left, op[1:0]}
    localparam logic [`ALUOPSIZE-1:0] OP_ADD = `ALUOPSIZE'({4'b0000, `ALUOP_ADD});
    localparam logic [`ALUOPSIZE-1:0] OP_SHL = `ALUOPSIZE'({4'b0011, `ALUOP_ADD});

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   acc, mc, mp;
    logic [CW-1:0]  cnt;
    logic           add_done;
    logic           do_add;
    logic           last_shift;
    logic           start_done;

    // Each multiplier bit costs a SHIFT, plus an ADD first when the bit is set.
    assign do_add = mp[0] & ~add_done;

`ifdef MULSEQ_EARLY_EXIT_EN
    assign last_shift = (cnt == CW'(W - 1)) || (mp[W-1:1] == '0);
    assign start_done = (in_b == '0);
`else
    assign last_shift = (cnt == CW'(W - 1));
    assign start_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_prod  = '0;
        alu_req   = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_shamt = '0;
        alu_aluop = '0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = start_done ? S_DONE : S_ITER;
            end
            S_ITER: begin
                alu_req = 1'b1;
                if (do_add) begin
                    alu_a     = acc;
                    alu_b     = mc;
                    alu_aluop = OP_ADD;
                end else begin
                    alu_a     = mc;
                    alu_shamt = `SHAMTSIZE'(1);
                    alu_aluop = OP_SHL;
                    if (alu_gnt && last_shift) state_nx = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                out_prod  = acc;
                if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            mc       <= '0;
            mp       <= '0;
            cnt      <= '0;
            add_done <= 1'b0;
        end else if (state == S_IDLE) begin
            if (in_valid) begin
                acc      <= '0;
                mc       <= in_a;
                mp       <= in_b;
                cnt      <= '0;
                add_done <= 1'b0;
            end
        end else if (state == S_ITER && alu_gnt) begin
            // Ungranted cycles leave everything untouched so the same op reissues.
            if (do_add) begin
                acc      <= alu_res;
                add_done <= 1'b1;
            end else begin
                mc       <= alu_res;
                mp       <= mp >> 1;
                cnt      <= cnt + CW'(1);
                add_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: behavioural ALU, latency / hold / reset checks.
`timescale 1ns/1ps

`ifndef WORDSIZE
`define WORDSIZE 64
`endif
`ifndef SHAMTSIZE
`define SHAMTSIZE 6
`endif
`ifndef ALUOPSIZE
`define ALUOPSIZE 6
`endif

module tb_mul_seq;
    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [`WORDSIZE-1:0]  in_a = '0;
    logic [`WORDSIZE-1:0]  in_b = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [`WORDSIZE-1:0]  out_prod;
    logic                  alu_req;
    logic                  alu_gnt = 1'b1;
    logic [`WORDSIZE-1:0]  alu_a, alu_b, alu_res;
    logic [`SHAMTSIZE-1:0] alu_shamt;
    logic [`ALUOPSIZE-1:0] alu_aluop;

    int checks = 0;
    int errors = 0;

    mul_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
        .alu_shamt(alu_shamt), .alu_aluop(alu_aluop), .alu_res(alu_res)
    );

    always #5 clk = ~clk;

    // Shared ALU: optional operand inversion, add, optional shift.
    logic [`WORDSIZE-1:0] opa, opb, sum;
    always_comb begin
        opa = alu_aluop[5] ? ~alu_a : alu_a;
        opb = alu_aluop[4] ? ~alu_b : alu_b;
        sum = opa + opb;
        if (alu_aluop[3]) alu_res = alu_aluop[2] ? (sum << alu_shamt) : (sum >> alu_shamt);
        else              alu_res = sum;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // alt: grant alternates starting at 0; hold: out_ready low for 10 cycles of DONE.
    task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input bit alt, input bit hold, input int exp_iter, input logic [63:0] exp_prod);
        int cyc, iter;
        bit g;
        logic [63:0] pa, pb, po;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_a = a; in_b = b; in_valid = 1'b1;
        out_ready = !hold;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1; iter = 0; g = !alt;
        while (!out_valid && cyc < 1000) begin
            alu_gnt = g;
            if (alu_req) iter++;
            pa = alu_a; pb = alu_b; po = 64'(alu_aluop);
            @(posedge clk); #1;
            if (!g) begin
                chk({tag, "_hold_a"}, alu_a, pa);
                chk({tag, "_hold_b"}, alu_b, pb);
                chk({tag, "_hold_op"}, 64'(alu_aluop), po);
            end
            cyc++;
            if (alt) g = !g;
        end
        alu_gnt = 1'b1;
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_iter"}, 64'(iter), 64'(exp_iter));
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_iter + 1));
        chk({tag, "_prod"}, out_prod, exp_prod);
        if (hold) begin
            in_a = 64'd3; in_b = 64'd3; in_valid = 1'b1;
            repeat (10) begin
                @(posedge clk); #1;
                chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
                chk({tag, "_stall_prod"}, out_prod, exp_prod);
                chk({tag, "_stall_rdy"}, 64'(in_ready), 64'd0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_post_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_prod", out_prod, 64'd0);
        chk("rst_alu_req", 64'(alu_req), 64'd0);
        chk("rst_alu_a", alu_a, 64'd0);
        chk("rst_alu_b", alu_b, 64'd0);
        chk("rst_alu_op", 64'({alu_shamt, alu_aluop}), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef MULSEQ_EARLY_EXIT_EN
        run("m5x3",   64'd5, 64'd3, 1'b0, 1'b0, 4, 64'd15);
        run("mones",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 128, 64'd1);
        run("m7x6alt", 64'd7, 64'd6, 1'b1, 1'b0, 10, 64'd42);
        run("mhold",  64'd12, 64'd10, 1'b0, 1'b1, 6, 64'd120);
        run("mzero",  64'd123, 64'd0, 1'b0, 1'b0, 0, 64'd0);
        run("movf",   64'h8000_0000_0000_0001, 64'd2, 1'b0, 1'b0, 3, 64'd2);
`else
        run("m5x3",   64'd5, 64'd3, 1'b0, 1'b0, 66, 64'd15);
        run("mones",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 128, 64'd1);
        run("m7x6alt", 64'd7, 64'd6, 1'b1, 1'b0, 132, 64'd42);
        run("mhold",  64'd12, 64'd10, 1'b0, 1'b1, 66, 64'd120);
        run("mzero",  64'd123, 64'd0, 1'b0, 1'b0, 64, 64'd0);
        run("movf",   64'h8000_0000_0000_0001, 64'd2, 1'b0, 1'b0, 65, 64'd2);
`endif

        // Abort mid-ITER with an asynchronous reset pulse.
        in_a = 64'd5; in_b = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("abort_in_iter", 64'(alu_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_out_prod", out_prod, 64'd0);
        chk("abort_alu_req", 64'(alu_req), 64'd0);
        chk("abort_alu_ab", alu_a | alu_b, 64'd0);
        chk("abort_alu_op", 64'({alu_shamt, alu_aluop}), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_valid", 64'(out_valid), 64'd0);
`ifdef MULSEQ_EARLY_EXIT_EN
        run("m9x9", 64'd9, 64'd9, 1'b0, 1'b0, 6, 64'd81);
`else
        run("m9x9", 64'd9, 64'd9, 1'b0, 1'b0, 66, 64'd81);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle integer multiply sequencer that computes the low `WORDSIZE` bits of a product by driving the shared ALU through shift-add iterations. It sits beside the execute stage. It requests the ALU from the datapath arbiter, issues one ALU operation per granted cycle, and returns the product through a valid/ready handshake. Two's-complement and unsigned MUL give the same low word, so signedness is irrelevant.

## Interface
- No parameters; widths come from `WORDSIZE`, `SHAMTSIZE` and `ALUOPSIZE` (bus.vh, aluop.vh).
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  sequencer idle, operands accepted
- in_a  in  `WORDSIZE`  multiplicand
- in_b  in  `WORDSIZE`  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- out_prod  out  `WORDSIZE`  low word of in_a*in_b
- alu_req  out  1  ALU requested
- alu_gnt  in  1  ALU granted this cycle
- alu_a  out  `WORDSIZE`  ALU operand A
- alu_b  out  `WORDSIZE`  ALU operand B
- alu_shamt  out  `SHAMTSIZE`  ALU shift amount
- alu_aluop  out  `ALUOPSIZE`  ALU operation
- alu_res  in  `WORDSIZE`  ALU result (flags unused)

## Operation
- aluop fields: [5] invert A, [4] invert B, [3] shift enable, [2] direction (1 = left), [1:0] = `ALUOP_ADD`. Result = (A op B) shifted.
- Registers:
  - acc: product accumulator
  - mc: shifted multiplicand
  - mp: remaining multiplier
  - cnt: bits done, width clog2(`WORDSIZE`)+1
- States:
  - IDLE: in_ready=1. On in_valid: acc=0, mc=in_a, mp=in_b, cnt=0, go to ITER.
  - ITER: alu_req=1. Nothing updates in a cycle where alu_gnt=0.
    - ADD op (when mp[0]=1 and add_done=0): alu_a=acc, alu_b=mc, aluop=ADD with no shift. acc<=alu_res; add_done<=1.
    - SHIFT op (otherwise): alu_a=mc, alu_b=0, aluop=ADD with shift-left enabled, shamt=1. mc<=alu_res; mp<=mp>>1; cnt<=cnt+1; add_done<=0.
    - The last SHIFT (cnt becomes `WORDSIZE`) goes to DONE.
  - DONE: out_valid=1, out_prod=acc. Product is held stable until out_ready=1, then go to IDLE.
- Not in ITER: alu_req=0, alu_a=alu_b=0, alu_shamt=0, alu_aluop=0.
- Overflow above `WORDSIZE` bits is discarded; ALU carry is ignored.
- in_valid outside IDLE is ignored; in_ready=0 there.

## Timing
- Reset values: in_ready=1, out_valid=0, out_prod=0, alu_req=0, all alu_* outputs 0. State is IDLE, all registers 0.
- Reset asserted mid-operation aborts immediately. The in-flight operation is lost and no out_valid is produced.
- Accept at edge k puts ITER in cycle k+1.
- Base latency with continuous grant: `WORDSIZE` + popcount(in_b) ITER cycles, then out_valid in the following cycle.
- Each alu_gnt=0 cycle adds exactly one cycle.
- The earliest next accept is the cycle after the out_valid&&out_ready handshake. There is no same-cycle turnaround.
- alu_* outputs are combinational from state; alu_res is sampled at the same edge.

## Configuration
- MULSEQ_EARLY_EXIT_EN defined:
  - Accepting in_b=0 goes straight to DONE, so out_valid appears the cycle after accept with product 0.
  - In ITER, a SHIFT that leaves mp=0 goes to DONE regardless of cnt.
  - Latency = 2·(index of highest set bit of in_b + 1) minus zero bits of in_b below that index, in ITER cycles.
- Undefined: the fixed `WORDSIZE`-iteration behaviour above.

## Test plan
- a=5, b=3, grant tied 1, no EARLY_EXIT:
  - out_prod=15.
  - out_valid 67 cycles after accept with `WORDSIZE`=64 (66 ITER cycles plus 1).
- Same stimulus with MULSEQ_EARLY_EXIT_EN:
  - 4 ITER cycles (ADD, SHIFT, ADD, SHIFT).
  - out_valid on cycle 5 after accept, out_prod=15.
- a=0xFFFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF:
  - out_prod=1.
  - 128 ITER cycles.
- a=7, b=6 with alu_gnt alternating 0/1:
  - Latency is exactly doubled in ITER.
  - acc, mc, mp unchanged on ungranted cycles.
  - out_prod=42.
- out_ready held 0 for 10 cycles after out_valid:
  - out_valid and out_prod stay stable.
  - in_ready stays 0 and a pending in_valid is not accepted.
- rst_n pulsed low mid-ITER:
  - All outputs at reset values immediately.
  - Next operation a=9, b=9 returns 81.
